mode_controller: RTL
====================

# mode_controller

Top-level mode sequencer for the calculator front panel. Decodes the five mode switches on a confirm press and sequences the system through DEFAULT, STORE, GEN, SHOW, CALC and SETUP. Returns to DEFAULT when the active sub-unit finishes, faults, or the user backs out. Drives the mode, error and blink inputs of the LED display block, and gives sub-units a one-cycle entry strobe.

## Interface
- BLINK_HALF, 50_000_000: cycles per blink half-period (0.5 s at 100 MHz); minimum 2
- ERR_BLINKS, 3: full blink periods (on+off) an error is shown before auto-clear
- clk  input  1  system clock; one clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mode_sw  input  5  mode-select switches; bit0 STORE, bit1 GEN, bit2 SHOW, bit3 CALC, bit4 SETUP
- confirm_pulse  input  1  debounced single-cycle confirm press
- back_pulse  input  1  debounced single-cycle back/abort press
- op_done  input  1  single-cycle completion strobe from the active sub-unit
- op_error  input  1  single-cycle fault strobe from the active sub-unit
- mode_state  output  3  current mode: 0 DEFAULT, 1 STORE, 2 GEN, 3 SHOW, 4 CALC, 5 SETUP
- mode_enter  output  1  one-cycle strobe on the first cycle of a non-DEFAULT mode
- error_active  output  1  error indication in force (DEFAULT only)
- blink_bit  output  1  blink phase; 1 = LEDs lit

## Operation
- States equal mode_state values. All outputs are registered.
- **DEFAULT, no error, confirm_pulse:**
  - mode_sw exactly one-hot: enter the matching mode and assert mode_enter.
  - mode_sw zero or multi-hot: stay in DEFAULT and set error_active.
- **DEFAULT with error_active:**
  - confirm_pulse or back_pulse clears the error only. The press is consumed; no mode entry occurs on that press.
  - mode_sw changes have no effect.
- **Any non-DEFAULT mode:**
  - op_error: go to DEFAULT and set error_active.
  - op_done or back_pulse: go to DEFAULT with no error.
  - confirm_pulse is ignored.
- **Simultaneous events:**
  - op_error outranks op_done and back_pulse; the error is still raised.
  - op_done and back_pulse in the same cycle give one return to DEFAULT.
- **Blink:**
  - On error entry, blink_bit = 1 and the counter is 0.
  - The counter counts 0..BLINK_HALF-1; on the terminal count blink_bit toggles and the counter wraps to 0.
  - While error_active is 0, the counter holds 0 and blink_bit = 0.
- **Error and mode:**
  - error_active is only ever 1 while mode_state = DEFAULT.
  - An invalid mode_state encoding (6, 7) forces DEFAULT with no error on the next cycle.

## Timing
- Reset values: mode_state = 0, mode_enter = 0, error_active = 0, blink_bit = 0, counters = 0.
- Reset mid-mode or mid-error reaches these values on the next edge.
- Input pulse sampled at edge N → mode_state, error_active and mode_enter update at edge N+1. Latency is 1 cycle, with no combinational input-to-output paths.
- mode_enter is high exactly one cycle, coincident with the first cycle of the new mode_state.
- With auto-clear, error_active is high for exactly 2·ERR_BLINKS·BLINK_HALF cycles. It deasserts on the edge that would start the next "on" phase, with blink_bit = 0 at that edge.
- A confirm or back press on the same cycle as auto-clear expiry counts only as a clear; no mode entry.

## Configuration
- Macro: MODE_CTRL_ERR_AUTOCLR_EN.
- **Defined:** a blink-period counter (width $clog2(ERR_BLINKS+1)) counts completed off-phases. error_active clears automatically after ERR_BLINKS periods, or earlier on confirm or back.
- **Undefined:** no period counter is synthesised. error_active holds, blinking indefinitely, until confirm_pulse or back_pulse.

## Structure
- **Shared package `mode_pkg`:**
  - localparams MODE_DEFAULT = 3'd0 through MODE_SETUP = 3'd5, and MODE_W = 3.
  - A function onehot5(sw) returning valid flag plus target mode.
  - The LED display and all sub-units import the same encodings.
- **Sub-module `blink_timer`:**
  - Inputs: clk, rst, start, run.
  - Outputs: blink_bit, period_done strobe.
  - Parameters: BLINK_HALF.
- The period count and the FSM stay in mode_controller.

## Test plan
Bench parameters: BLINK_HALF = 4, ERR_BLINKS = 2, macro defined unless stated.

- mode_sw = 5'b00100, confirm at cycle 10 → mode_state = 3 and mode_enter = 1 at cycle 11 only; op_done at 20 → mode_state = 0 at 21, error_active = 0.
- mode_sw = 5'b00110, confirm → error_active = 1, blink_bit = 1 for 4 cycles then 0 for 4 cycles, repeated twice; error_active = 0 after exactly 16 cycles; mode_state stays 0.
- In CALC (mode_sw 5'b01000), op_error and op_done in the same cycle → next cycle mode_state = 0 and error_active = 1.
- Error active, confirm with mode_sw = 5'b00001 → error clears and mode_state stays 0; a second confirm → mode_state = 1 with mode_enter pulse.
- Macro undefined, mode_sw = 0 with confirm → error_active still 1 after 100 cycles with blink toggling every 4; back_pulse clears it next cycle.
- rst asserted during SETUP with error pending → all outputs 0 on the next edge; the confirm press sampled in the reset cycle is ignored.

Source files
------------

// File: rtl/mode_pkg.sv
// Shared mode encodings for the calculator front panel.
// The LED display and every sub-unit import these so the mode numbers agree.
package mode_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_DEFAULT = 3'd0;
  localparam logic [MODE_W-1:0] MODE_STORE   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_GEN     = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHOW    = 3'd3;
  localparam logic [MODE_W-1:0] MODE_CALC    = 3'd4;
  localparam logic [MODE_W-1:0] MODE_SETUP   = 3'd5;

  // State encoding equals the externally visible mode number.
  typedef enum logic [MODE_W-1:0] {
    ST_DEFAULT = MODE_DEFAULT,
    ST_STORE   = MODE_STORE,
    ST_GEN     = MODE_GEN,
    ST_SHOW    = MODE_SHOW,
    ST_CALC    = MODE_CALC,
    ST_SETUP   = MODE_SETUP
  } mode_e;

  typedef struct packed {
    logic              valid;
    logic [MODE_W-1:0] mode;
  } sw_decode_t;

  // Exactly one switch up selects a mode; anything else is a user error.
  function automatic sw_decode_t onehot5(input logic [4:0] sw);
    sw_decode_t r;
    r.valid = 1'b1;
    r.mode  = MODE_DEFAULT;
    case (sw)
      5'b00001: r.mode = MODE_STORE;
      5'b00010: r.mode = MODE_GEN;
      5'b00100: r.mode = MODE_SHOW;
      5'b01000: r.mode = MODE_CALC;
      5'b10000: r.mode = MODE_SETUP;
      default:  r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mode_controller_if.sv
// Front-panel / sub-unit bus of the mode controller.
// Strobe semantics: confirm_pulse, back_pulse, op_done and op_error are
// single-cycle pulses, each counted once on the rising edge where it is high;
// there is no back-pressure. mode_enter is the controller's single-cycle
// strobe on the first cycle of a new non-DEFAULT mode.
interface mode_controller_if;
  import mode_pkg::*;

  logic [4:0]        mode_sw;
  logic              confirm_pulse;
  logic              back_pulse;
  logic              op_done;
  logic              op_error;
  logic [MODE_W-1:0] mode_state;
  logic              mode_enter;
  logic              error_active;
  logic              blink_bit;

  modport master (
    output mode_sw, confirm_pulse, back_pulse, op_done, op_error,
    input  mode_state, mode_enter, error_active, blink_bit
  );

  modport slave (
    input  mode_sw, confirm_pulse, back_pulse, op_done, op_error,
    output mode_state, mode_enter, error_active, blink_bit
  );
endinterface

// File: rtl/blink_timer.sv
// Half-period blink timer for the error indication.
// start restarts the "on" phase at count 0; while run is low the timer is
// parked dark. period_done flags the last cycle of an "off" phase, i.e. the
// edge that completes one full blink period.
module blink_timer #(
  parameter int BLINK_HALF = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic blink_bit,
  output logic period_done
);

  localparam int CW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt;

  // Half-period counter and blink phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      blink_bit <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      blink_bit <= 1'b1;
    end else if (!run) begin
      cnt       <= '0;
      blink_bit <= 1'b0;
    end else if (cnt == LAST) begin
      cnt       <= '0;
      blink_bit <= ~blink_bit;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Derived from registers only, so no path back into the controller logic.
  assign period_done = !blink_bit && (cnt == LAST);

endmodule

// File: rtl/mode_controller.sv
// Top-level mode sequencer for the calculator front panel.
// Optional feature macro MODE_CTRL_ERR_AUTOCLR_EN: when defined, an error
// indication clears itself after ERR_BLINKS full blink periods; otherwise it
// blinks until the user presses confirm or back.
module mode_controller
  import mode_pkg::*;
#(
  parameter int BLINK_HALF = 50_000_000,
  parameter int ERR_BLINKS = 3
) (
  input logic clk,
  input logic rst,
  mode_controller_if.slave bus
);

  mode_e      state;
  logic       mode_enter;
  logic       error_active;
  logic       blink_bit;
  logic       period_done;
  logic       auto_clr;
  logic       mode_active;
  logic       err_set;
  logic       err_clr;
  logic       error_next;
  sw_decode_t sw_dec;

`ifdef MODE_CTRL_ERR_AUTOCLR_EN
  localparam int PW = (ERR_BLINKS > 1) ? $clog2(ERR_BLINKS + 1) : 1;
  logic [PW-1:0] per_cnt;
  assign auto_clr = period_done && (per_cnt == PW'(ERR_BLINKS - 1));
`else
  logic unused_period_done;
  assign unused_period_done = period_done;
  assign auto_clr = 1'b0;
`endif

  // Event decode: when an error is raised or cleared, and the next error flag.
  always_comb begin
    sw_dec      = onehot5(bus.mode_sw);
    mode_active = (state == ST_STORE) || (state == ST_GEN) || (state == ST_SHOW) ||
                  (state == ST_CALC) || (state == ST_SETUP);
    err_set     = ((state == ST_DEFAULT) && !error_active && bus.confirm_pulse &&
                   !sw_dec.valid) || (mode_active && bus.op_error);
    err_clr     = error_active && (bus.confirm_pulse || bus.back_pulse || auto_clr);
    error_next  = err_set || (error_active && !err_clr);
  end

  // Mode FSM; all outputs registered, updated one edge after the input pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_DEFAULT;
      mode_enter   <= 1'b0;
      error_active <= 1'b0;
`ifdef MODE_CTRL_ERR_AUTOCLR_EN
      per_cnt      <= '0;
`endif
    end else begin
      mode_enter   <= 1'b0;
      error_active <= error_next;
      case (state)
        ST_DEFAULT: begin
          // A press while the error shows only clears it.
          if (!error_active && bus.confirm_pulse && sw_dec.valid) begin
            state      <= mode_e'(sw_dec.mode);
            mode_enter <= 1'b1;
          end
        end
        ST_STORE, ST_GEN, ST_SHOW, ST_CALC, ST_SETUP: begin
          if (bus.op_error || bus.op_done || bus.back_pulse) begin
            state <= ST_DEFAULT;
          end
        end
        default: begin
          state        <= ST_DEFAULT;
          error_active <= 1'b0;
        end
      endcase
`ifdef MODE_CTRL_ERR_AUTOCLR_EN
      if (err_set) begin
        per_cnt <= '0;
      end else if (error_active && period_done) begin
        per_cnt <= per_cnt + 1'b1;
      end
`endif
    end
  end

  blink_timer #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (err_set),
    .run        (error_next),
    .blink_bit  (blink_bit),
    .period_done(period_done)
  );

  assign bus.mode_state   = state;
  assign bus.mode_enter   = mode_enter;
  assign bus.error_active = error_active;
  assign bus.blink_bit    = blink_bit;

endmodule
